clk_enable_divider: RTL and testbench

// Parametrised, runtime-programmable clock divider for the VGA/display path and other slow logic.

---
 rtl/clkdiv_pkg.sv | 17 +
 rtl/clkdiv_phase_ctr.sv | 42 ++++
 rtl/clk_enable_divider.sv | 142 ++++++++++++++
 tb/tb_clk_enable_divider.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the clock-enable divider.
//   div_t           default-width divisor type (8 bits)
//   clkdiv_state_e  divider run state: IDLE (held at phase 0) or RUN
//   MIN_DIV         smallest divisor accepted by a load
package clkdiv_pkg;

    localparam int CLKDIV_DIV_W = 8;
    localparam int MIN_DIV      = 1;

    typedef logic [CLKDIV_DIV_W-1:0] div_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } clkdiv_state_e;

endpackage

// File: rtl/clkdiv_phase_ctr.sv
// Phase counter for the clock-enable divider.
// Counts 0..div-1 while advance is high and returns to 0 when advance is low.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   advance      1 = step the phase this cycle, 0 = force phase to 0
//   div          active divisor (must be >= 1)
//   phase        current phase register
//   phase_next   value phase takes at the next edge (used for output decode)
//   at_term      phase is at its terminal value div-1
module clkdiv_phase_ctr #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic [DIV_W-1:0] div,
    output logic [DIV_W-1:0] phase,
    output logic [DIV_W-1:0] phase_next,
    output logic             at_term
);

    logic [DIV_W-1:0] phase_reg;

    assign phase   = phase_reg;
    assign at_term = (phase_reg == (div - DIV_W'(1)));

    always_comb begin
        phase_next = '0;
        if (advance && !at_term) begin
            phase_next = phase_reg + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_next;
        end
    end

endmodule

// File: rtl/clk_enable_divider.sv
// Runtime-programmable clock divider producing a one-cycle enable pulse every
// D clock cycles and a registered divided clock high for ceil(D/2) cycles.
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   en_i      run enable; low holds the divider idle at phase 0
//   load_i    strobe: capture div_i as the new divisor
//   div_i     requested divisor (1..2**DIV_W-1); 0 is rejected
//   tick_o    one-cycle enable pulse at phase 0
//   clk_o     divided clock, high while phase < ceil(D/2)
//   phase_o   current phase 0..D-1
//   busy_o    a loaded divisor waits for the period boundary
//   err_o     sticky flag: a zero divisor load was rejected
module clk_enable_divider
    import clkdiv_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic             clk_o,
    output logic [DIV_W-1:0] phase_o,
    output logic             busy_o,
    output logic             err_o
);

    clkdiv_state_e    state_reg, state_next;
    logic [DIV_W-1:0] active_reg, active_next;
    logic [DIV_W-1:0] shadow_reg, shadow_next;
    logic             busy_reg, busy_next;
    logic             err_reg, err_next;
    logic             tick_reg, tick_next;
    logic             clk_reg, clk_next;

    logic             run_cont;
    logic             load_ok;
    logic             at_term;
    logic [DIV_W-1:0] phase_next;
    logic [DIV_W:0]   half_div;
    logic             run_next;

    // Stay in RUN and keep counting only when already running and still enabled;
    // entering RUN starts at phase 0.
    assign run_cont = (state_reg == RUN) && en_i;
    assign load_ok  = load_i && (div_i >= DIV_W'(MIN_DIV));

    clkdiv_phase_ctr #(
        .DIV_W(DIV_W)
    ) u_phase_ctr (
        .clk       (clk),
        .reset     (reset),
        .advance   (run_cont),
        .div       (active_reg),
        .phase     (phase_o),
        .phase_next(phase_next),
        .at_term   (at_term)
    );

    always_comb begin
        state_next  = state_reg;
        active_next = active_reg;
        shadow_next = shadow_reg;
        busy_next   = busy_reg;
        err_next    = err_reg;

        if (state_reg == IDLE) begin
            // No period in progress, so a load takes effect immediately.
            if (load_ok) begin
                active_next = div_i;
                shadow_next = div_i;
            end
            if (en_i) begin
                state_next = RUN;
            end
        end else if (!en_i) begin
            // Leaving RUN: whatever divisor is newest becomes active right away.
            state_next = IDLE;
            busy_next  = 1'b0;
            if (load_ok) begin
                active_next = div_i;
                shadow_next = div_i;
            end else if (busy_reg) begin
                active_next = shadow_reg;
            end
        end else if (at_term) begin
            // Wrap edge. A load arriving on this very edge is only captured;
            // it applies at the following wrap.
            if (load_ok) begin
                shadow_next = div_i;
                busy_next   = 1'b1;
            end else if (busy_reg) begin
                active_next = shadow_reg;
                busy_next   = 1'b0;
            end
        end else if (load_ok) begin
            shadow_next = div_i;
            busy_next   = 1'b1;
        end

        if (load_i && !load_ok) begin
            err_next = 1'b1;
        end
    end

    // Outputs are decoded from the upcoming phase and divisor so they are
    // aligned with phase_o after the edge.
    assign run_next  = (state_next == RUN);
    assign half_div  = ({1'b0, active_next} + (DIV_W+1)'(1)) >> 1;
    assign tick_next = run_next && (phase_next == '0);
    assign clk_next  = run_next && ({1'b0, phase_next} < half_div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            active_reg <= DIV_W'(DEFAULT_DIV);
            shadow_reg <= DIV_W'(DEFAULT_DIV);
            busy_reg   <= 1'b0;
            err_reg    <= 1'b0;
            tick_reg   <= 1'b0;
            clk_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            active_reg <= active_next;
            shadow_reg <= shadow_next;
            busy_reg   <= busy_next;
            err_reg    <= err_next;
            tick_reg   <= tick_next;
            clk_reg    <= clk_next;
        end
    end

    assign tick_o = tick_reg;
    assign clk_o  = clk_reg;
    assign busy_o = busy_reg;
    assign err_o  = err_reg;

endmodule

// File: tb/tb_clk_enable_divider.sv
// Directed bench for clk_enable_divider with a cycle-level reference model.
// Each step drives inputs, pushes the model's expected outputs to a queue and
// pops/compares them one edge later.
module tb_clk_enable_divider;

    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 2;

    logic             clk;
    logic             reset;
    logic             en_i;
    logic             load_i;
    logic [DIV_W-1:0] div_i;
    logic             tick_o;
    logic             clk_o;
    logic [DIV_W-1:0] phase_o;
    logic             busy_o;
    logic             err_o;

    clk_enable_divider #(
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en_i   (en_i),
        .load_i (load_i),
        .div_i  (div_i),
        .tick_o (tick_o),
        .clk_o  (clk_o),
        .phase_o(phase_o),
        .busy_o (busy_o),
        .err_o  (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       clk;
        logic [7:0] phase;
        logic       busy;
        logic       err;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    bit m_run;
    int m_d;
    int m_shadow;
    bit m_busy;
    bit m_err;
    int m_p;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run    = 0;
        m_d      = DEFAULT_DIV;
        m_shadow = DEFAULT_DIV;
        m_busy   = 0;
        m_err    = 0;
        m_p      = 0;
    endtask

    // Advance the model by one clock edge with the given sampled inputs.
    task automatic model_step(input bit en, input bit ld, input int dv, output exp_t e);
        bit good;
        good = ld && (dv != 0);
        if (ld && dv == 0) m_err = 1;
        if (!m_run) begin
            if (good) begin m_d = dv; m_shadow = dv; end
            m_run = en;
            m_p   = 0;
        end else if (!en) begin
            if (good) begin m_d = dv; m_shadow = dv; end
            else if (m_busy) m_d = m_shadow;
            m_busy = 0;
            m_run  = 0;
            m_p    = 0;
        end else if (m_p == m_d - 1) begin
            m_p = 0;
            if (good) begin m_shadow = dv; m_busy = 1; end
            else if (m_busy) begin m_d = m_shadow; m_busy = 0; end
        end else begin
            m_p = m_p + 1;
            if (good) begin m_shadow = dv; m_busy = 1; end
        end
        e.tick  = m_run && (m_p == 0);
        e.clk   = m_run && (m_p < (m_d + 1) / 2);
        e.phase = 8'(m_p);
        e.busy  = m_busy;
        e.err   = m_err;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit en, input bit ld, input int dv);
        exp_t e;
        exp_t got;
        en_i   = en;
        load_i = ld;
        div_i  = 8'(dv);
        model_step(en, ld, dv, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        got = sb.pop_front();
        $display("cyc %0d en=%0d load=%0d div=%0d -> tick=%0d clk_o=%0d phase=%0d busy=%0d err=%0d",
                 cyc, en, ld, dv, tick_o, clk_o, phase_o, busy_o, err_o);
        chk("tick", 32'(tick_o), 32'(got.tick));
        chk("clk_o", 32'(clk_o), 32'(got.clk));
        chk("phase", 32'(phase_o), 32'(got.phase));
        chk("busy", 32'(busy_o), 32'(got.busy));
        chk("err", 32'(err_o), 32'(got.err));
        @(negedge clk);
        load_i = 1'b0;
    endtask

    initial begin
        int guard;
        reset  = 1'b1;
        en_i   = 1'b0;
        load_i = 1'b0;
        div_i  = '0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_tick", 32'(tick_o), 32'd0);
        chk("rst_clk", 32'(clk_o), 32'd0);
        chk("rst_phase", 32'(phase_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        reset = 1'b0;

        // 1: default D=2
        step(1, 0, 0);
        chk("t1_first_tick", 32'(tick_o), 32'd1);
        repeat (6) step(1, 0, 0);

        // 2: load 5 mid-period (now at p=0 of D=2)
        step(1, 1, 5);
        chk("t2_busy_set", 32'(busy_o), 32'd1);
        chk("t2_phase_old_d", 32'(phase_o), 32'd1);
        step(1, 0, 0);
        chk("t2_busy_clear", 32'(busy_o), 32'd0);
        repeat (11) step(1, 0, 0);

        // 3: zero divisor is rejected and err sticks
        step(1, 1, 0);
        chk("t3_err", 32'(err_o), 32'd1);
        repeat (6) step(1, 0, 0);
        step(1, 1, 3);
        repeat (8) step(1, 0, 0);
        chk("t3_err_sticky", 32'(err_o), 32'd1);

        // 4: D=1, then D=7 with disable at p=3, then re-enable
        step(0, 1, 1);
        repeat (4) step(1, 0, 0);
        chk("t4_d1_tick", 32'(tick_o), 32'd1);
        chk("t4_d1_clk", 32'(clk_o), 32'd1);
        step(1, 1, 7);
        guard = 0;
        while (m_p != 3 && guard < 30) begin
            step(1, 0, 0);
            guard++;
        end
        chk("t4_reach_p3", 32'(phase_o), 32'd3);
        step(0, 0, 0);
        chk("t4_idle_tick", 32'(tick_o), 32'd0);
        chk("t4_idle_clk", 32'(clk_o), 32'd0);
        chk("t4_idle_phase", 32'(phase_o), 32'd0);
        step(0, 0, 0);
        step(1, 0, 0);
        chk("t4_reen_tick", 32'(tick_o), 32'd1);
        repeat (8) step(1, 0, 0);

        // 5: load 4 on the wrap edge of D=3
        step(0, 1, 3);
        step(1, 0, 0);
        guard = 0;
        while (m_p != 2 && guard < 30) begin
            step(1, 0, 0);
            guard++;
        end
        chk("t5_reach_term", 32'(phase_o), 32'd2);
        step(1, 1, 4);
        chk("t5_captured", 32'(busy_o), 32'd1);
        repeat (3) step(1, 0, 0);
        chk("t5_old_period_tick", 32'(tick_o), 32'd1);
        repeat (9) step(1, 0, 0);

        // 6: asynchronous reset at p=2 of D=6
        step(0, 1, 6);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("t6_at_p2", 32'(phase_o), 32'd2);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t6_async_tick", 32'(tick_o), 32'd0);
        chk("t6_async_clk", 32'(clk_o), 32'd0);
        chk("t6_async_phase", 32'(phase_o), 32'd0);
        chk("t6_async_err", 32'(err_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 0);
        chk("t6_post_tick", 32'(tick_o), 32'd1);
        repeat (5) step(1, 0, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
